// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full-add cell (two half adders) is stepped
// across the operands LSB first, one bit per clock, behind a start/busy/done handshake.

module half_adder (
  input  logic in_a,
  input  logic in_b,
  output logic sum,
  output logic carry
);

  assign sum   = in_a ^ in_b;
  assign carry = in_a & in_b;

endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ha0_sum, ha0_carry;
  logic             bit_sum, ha1_carry;
  logic             bit_carry;
  logic [WIDTH-1:0] work_shift;

  half_adder u_ha0 (
    .in_a  (a_sh_q[0]),
    .in_b  (b_sh_q[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .in_a  (ha0_sum),
    .in_b  (carry_q),
    .sum   (bit_sum),
    .carry (ha1_carry)
  );

  assign bit_carry = ha0_carry | ha1_carry;

  // New sum bit enters at the MSB; the cast keeps WIDTH=1 legal without a slice.
  assign work_shift = WIDTH'({bit_sum, work_q} >> 1);

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          work_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        work_d  = work_shift;
        carry_d = bit_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          sum_d   = work_shift;
          cout_d  = bit_carry;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also aborts any addition in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: WIDTH=8 and WIDTH=1 instances,
// expected {carry_out,sum} queued at start and compared on each done pulse.

module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, busy, done, cout;
  logic [7:0] in_a, in_b, sum;
  logic       start1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] last_res;
  logic [8:0] exp8;
  logic [1:0] exp1;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .sum(sum), .carry_out(cout)
  );

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_a(a1), .in_b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // WIDTH=8 scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("busy_done_excl8", 32'(busy & done), 32'd0);
      if (done) begin
        check_val("done_has_exp8", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          exp8 = q8.pop_front();
          check_val("result8", 32'({cout, sum}), 32'(exp8));
        end
      end
    end
  end

  // WIDTH=1 scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("busy_done_excl1", 32'(busy1 & done1), 32'd0);
      if (done1) begin
        check_val("done_has_exp1", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          exp1 = q1.pop_front();
          check_val("result1", 32'({cout1, sum1}), 32'(exp1));
        end
      end
    end
  end

  // Called just after a negedge; returns just after the done negedge.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b};
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = 8'hFF;
    in_b  = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("run_busy", 32'(busy), 32'd1);
      check_val("run_done", 32'(done), 32'd0);
      check_val("run_hold", 32'({cout, sum}), 32'(last_res));
    end
    @(negedge clk);
    check_val("lat_done", 32'(done), 32'd1);
    check_val("lat_busy", 32'(busy), 32'd0);
    last_res = e;
  endtask

  task automatic add1(input logic [0:0] a, input logic [0:0] b);
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    q1.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    a1     = ~a;
    b1     = ~b;
    @(negedge clk);
    check_val("w1_busy", 32'({busy1, done1}), 32'b10);
    @(negedge clk);
    check_val("w1_done", 32'({busy1, done1}), 32'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    start1   = 1'b0;
    a1       = 1'b0;
    b1       = 1'b0;
    last_res = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_out8", 32'({busy, done, cout, sum}), 32'd0);
    check_val("rst_out1", 32'({busy1, done1, cout1, sum1}), 32'd0);

    do_add(8'h00, 8'h00);
    do_add(8'h5A, 8'h25);
    do_add(8'hFF, 8'h01);
    do_add(8'hFF, 8'hFF);

    // Start held high: ignored while busy, re-accepted in each DONE cycle.
    in_a  = 8'h12;
    in_b  = 8'h34;
    start = 1'b1;
    for (int k = 0; k < 3; k++) q8.push_back(9'h046);
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check_val("held_busy", 32'({busy, done}), 32'b10);
        check_val("held_hold", 32'({cout, sum}), 32'(last_res));
      end
      @(negedge clk);
      check_val("held_done", 32'({busy, done}), 32'b01);
      last_res = 9'h046;
      if (op == 2) start = 1'b0;
    end
    @(negedge clk);
    check_val("held_idle", 32'({busy, done}), 32'd0);

    // Reset in the middle of a run aborts it.
    in_a  = 8'hAA;
    in_b  = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_out", 32'({busy, done, cout, sum}), 32'd0);
    last_res = 9'h000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("abort_nodone", 32'({busy, done}), 32'd0);
    end
    do_add(8'h01, 8'h01);

    for (int i = 0; i < 200; i++) begin
      do_add(8'($urandom), 8'($urandom));
    end
    do_add(8'h80, 8'h80);
    do_add(8'h7F, 8'h01);

    for (int i = 0; i < 8; i++) add1(1'(i), 1'(i >> 1));
    for (int i = 0; i < 40; i++) add1(1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    check_val("q8_empty", 32'(q8.size()), 32'd0);
    check_val("q1_empty", 32'(q1.size()), 32'd0);
    check_val("final_idle", 32'({busy, done, busy1, done1}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
